// File: rtl/stage_if_pkg.sv
// ---------------------------------------------------------------------------
// stage_if_pkg
// Shared constants for the instruction-fetch stage: bus widths, fetch FSM
// state encodings and the 2-bit saturating-counter helper used by the
// branch predictor.
// ---------------------------------------------------------------------------
package stage_if_pkg;

    localparam int MEM_ADDR_W = 32;   // fetch address bus width
    localparam int INST_W     = 32;   // instruction word width

    // Fetch FSM encodings (kept as plain constants for legacy tools).
    localparam logic [1:0] IF_IDLE = 2'd0;   // no request outstanding
    localparam logic [1:0] IF_WAIT = 2'd1;   // request outstanding, data wanted
    localparam logic [1:0] IF_DROP = 2'd2;   // request outstanding, data discarded

    // Counter value given to a freshly allocated BTB entry (weakly taken).
    localparam logic [1:0] CNT_ALLOC = 2'd2;

    // Saturating 2-bit counter step: up when taken, down otherwise, range 0..3.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with a 2-bit direction counter per entry.
//   clk, reset        : clock, synchronous active-high reset (valid bits only)
//   lookup_pc         : address being fetched; index = pc[IDX_W+1:2]
//   lookup_taken      : entry valid, tag matches and counter predicts taken
//   lookup_target     : stored target of the indexed entry
//   upd_valid         : a branch/JAL resolved this cycle
//   upd_pc/taken/target : resolved PC, actual direction, actual target
// The lookup is combinational on the array contents, so a lookup in the same
// cycle as an update to the same index sees the pre-update entry.
// ---------------------------------------------------------------------------
module branch_predictor
    import stage_if_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MEM_ADDR_W-1:0] lookup_pc,
    output logic                  lookup_taken,
    output logic [MEM_ADDR_W-1:0] lookup_target,
    input  logic                  upd_valid,
    input  logic [MEM_ADDR_W-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [MEM_ADDR_W-1:0] upd_target
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = MEM_ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0]    valid;
    logic [TAG_W-1:0]      tag_mem    [ENTRIES];
    logic [MEM_ADDR_W-1:0] target_mem [ENTRIES];
    logic [1:0]            cnt_mem    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             unused_align;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[MEM_ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[MEM_ADDR_W-1:IDX_W+2];

    // Instructions are word aligned; the byte-offset bits carry no information.
    assign unused_align = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lookup_taken  = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) && cnt_mem[lk_idx][1];
    assign lookup_target = target_mem[lk_idx];

    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, which is also what makes same-cycle lookups
    // see the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (upd_valid && (up_hit || upd_taken)) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // NOTE: only the valid bits are reset; tag/target/counter arrays are
    // qualified by valid, so leaving them unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (up_hit) begin
                cnt_mem[up_idx] <= sat_update(cnt_mem[up_idx], upd_taken);
                if (upd_taken) begin
                    target_mem[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                cnt_mem[up_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/stage_if.sv
// ---------------------------------------------------------------------------
// stage_if
// Instruction-fetch stage: owns the fetch PC, issues one read at a time to the
// memory controller, and holds the fetched word in an output slot feeding the
// IF/ID latch. Taken branches are predicted through branch_predictor.
//   clk, reset         : clock, synchronous active-high reset
//   stall              : downstream cannot accept the slot
//   ex_redirect(_pc)   : restart fetch at the corrected PC (highest priority)
//   ex_br_*            : predictor update from a resolved branch/JAL
//   mem_req, mem_addr  : fetch request, address stable while pending
//   mem_ready, mem_inst: one-cycle response pulse and fetched word
//   if_valid, pc_o, inst_o, prediction_o : output slot
// ---------------------------------------------------------------------------
module stage_if
    import stage_if_pkg::*;
#(
    parameter int                    IDX_W    = 6,
    parameter logic [MEM_ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  ex_redirect,
    input  logic [MEM_ADDR_W-1:0] ex_redirect_pc,
    input  logic                  ex_br_valid,
    input  logic [MEM_ADDR_W-1:0] ex_br_pc,
    input  logic                  ex_br_taken,
    input  logic [MEM_ADDR_W-1:0] ex_br_target,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [INST_W-1:0]     mem_inst,
    output logic                  if_valid,
    output logic [MEM_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]     inst_o,
    output logic                  prediction_o
);

    logic [1:0]            state;
    logic [MEM_ADDR_W-1:0] pc;
    logic [MEM_ADDR_W-1:0] req_addr;
    logic                  pred;
    logic [MEM_ADDR_W-1:0] btb_target;
    logic                  slot_free;
    logic                  consumed;

    branch_predictor #(.IDX_W(IDX_W)) u_branch_predictor (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (req_addr),
        .lookup_taken  (pred),
        .lookup_target (btb_target),
        .upd_valid     (ex_br_valid),
        .upd_pc        (ex_br_pc),
        .upd_taken     (ex_br_taken),
        .upd_target    (ex_br_target)
    );

    assign mem_req   = (state != IF_IDLE);
    assign mem_addr  = req_addr;
    assign slot_free = !if_valid || !stall;
    assign consumed  = if_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IF_IDLE;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            if_valid     <= 1'b0;
            pc_o         <= '0;
            inst_o       <= '0;
            prediction_o <= 1'b0;
        end else begin
            // Default: a consumed slot empties; a reload or flush below
            // overrides this because the later assignment wins.
            if (consumed) begin
                if_valid <= 1'b0;
            end

            case (state)
                IF_IDLE: begin
                    if (ex_redirect) begin
                        pc       <= ex_redirect_pc;
                        req_addr <= ex_redirect_pc;
                        if_valid <= 1'b0;
                        state    <= IF_WAIT;
                    end else if (slot_free) begin
                        req_addr <= pc;
                        state    <= IF_WAIT;
                    end
                end

                IF_WAIT: begin
                    if (ex_redirect) begin
                        pc       <= ex_redirect_pc;
                        if_valid <= 1'b0;
                        if (mem_ready) begin
                            // Old word retired this cycle: reissue immediately.
                            req_addr <= ex_redirect_pc;
                        end else begin
                            // Old word still in flight: swallow it first.
                            state <= IF_DROP;
                        end
                    end else if (mem_ready) begin
                        pc_o         <= req_addr;
                        inst_o       <= mem_inst;
                        prediction_o <= pred;
                        if_valid     <= 1'b1;
                        pc           <= pred ? btb_target : req_addr + 32'd4;
                        state        <= IF_IDLE;
                    end
                end

                IF_DROP: begin
                    if (ex_redirect) begin
                        pc <= ex_redirect_pc;
                    end
                    if (mem_ready) begin
                        // A redirect landing on the same edge supersedes pc.
                        req_addr <= ex_redirect ? ex_redirect_pc : pc;
                        state    <= IF_WAIT;
                    end
                end

                default: state <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// ---------------------------------------------------------------------------
// tb_stage_if
// Randomized bench for stage_if. A stimulus process drives stall, redirects,
// predictor updates and a variable-latency memory, and runs a reference model
// of the fetch stream (next expected address, discard bookkeeping, BTB table)
// that pushes each expected slot item into a queue. A monitor process pops and
// compares whenever the slot is handed downstream, and checks stall/issue
// behaviour of the slot.
// ---------------------------------------------------------------------------
module tb_stage_if;

    localparam int          IDX_W    = 6;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          N_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic        if_valid;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        prediction_o;

    always #5 clk = ~clk;

    stage_if #(.IDX_W(IDX_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .ex_br_valid    (ex_br_valid),
        .ex_br_pc       (ex_br_pc),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_inst       (mem_inst),
        .if_valid       (if_valid),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .prediction_o   (prediction_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } item_t;

    item_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int ENTRIES = 1 << IDX_W;
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_pc;          // address the next kept request must use
    bit          drop_pending;  // the request in flight will be thrown away

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    function automatic bit predicts(input logic [31:0] a);
        int i = idx_of(a);
        return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_cnt[i] >= 2);
    endfunction

    task automatic model_update(input logic [31:0] bpc, input logic taken, input logic [31:0] tgt);
        int i = idx_of(bpc);
        if (m_valid[i] && m_tag[i] == tag_of(bpc)) begin
            if (taken) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(bpc);
            m_tgt[i]   = tgt;
            m_cnt[i]   = 2;
        end
    endtask

    // ---------------- stimulus + memory + model ----------------
    int    lat;
    bit    ready;
    bit    p;
    item_t it_new;

    initial begin
        reset = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
        ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0; ex_br_target = '0;
        mem_ready = 1'b0; mem_inst = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_req", mem_req, 0);
        check("reset_if_valid", if_valid, 0);
        check("reset_pc_o", pc_o, 0);
        check("reset_inst_o", inst_o, 0);
        check("reset_pred", prediction_o, 0);
        check("reset_mem_addr", mem_addr, RESET_PC);

        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
        end
        m_pc = RESET_PC;
        drop_pending = 1'b0;
        lat = 1;
        reset = 1'b0;

        @(posedge clk);
        #1;
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, RESET_PC);

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            stall          = ($urandom_range(3) == 0);
            ex_redirect    = (cyc > 20) && ($urandom_range(19) == 0);
            ex_redirect_pc = 32'($urandom_range(255)) * 4;

            ready = 1'b0;
            if (mem_req) begin
                if (lat == 0) begin
                    ready = 1'b1;
                    lat   = $urandom_range(2);
                end else begin
                    lat--;
                end
            end
            mem_ready = ready;
            mem_inst  = ready ? word_at(mem_addr) : $urandom;

            ex_br_valid  = ($urandom_range(2) == 0);
            ex_br_pc     = $urandom_range(1) ? m_pc : 32'($urandom_range(255)) * 4;
            ex_br_taken  = $urandom_range(1);
            ex_br_target = 32'($urandom_range(255)) * 4;

            // Model the upcoming edge: lookup first, predictor update after.
            if (ready) begin
                if (ex_redirect || drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    check("fetch_addr", mem_addr, m_pc);
                    p = predicts(m_pc);
                    it_new.pc   = m_pc;
                    it_new.inst = word_at(m_pc);
                    it_new.pred = p;
                    exp_q.push_back(it_new);
                    m_pc = p ? m_tgt[idx_of(m_pc)] : m_pc + 32'd4;
                end
            end
            if (ex_redirect) begin
                m_pc = ex_redirect_pc;
                if (mem_req && !ready) drop_pending = 1'b1;
            end
            if (ex_br_valid) model_update(ex_br_pc, ex_br_taken, ex_br_target);

            @(posedge clk);
            #1;
        end

        check("progress", (delivered > 200) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- monitor ----------------
    bit          chk_hold;
    bit          chk_issue;
    logic [31:0] h_pc;
    logic [31:0] h_inst;
    logic        h_pred;
    item_t       it_got;

    initial begin
        chk_hold  = 1'b0;
        chk_issue = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk_hold  = 1'b0;
                chk_issue = 1'b0;
            end else begin
                if (chk_hold) begin
                    check("stall_hold_valid", if_valid, 1);
                    check("stall_hold_pc", pc_o, h_pc);
                    check("stall_hold_inst", inst_o, h_inst);
                    check("stall_hold_pred", prediction_o, h_pred);
                end
                if (chk_issue) check("issue_after_consume", mem_req, 1);
                if (if_valid) check("no_req_while_full", mem_req, 0);

                chk_hold  = if_valid && stall && !ex_redirect;
                chk_issue = if_valid && !stall && !ex_redirect;
                h_pc = pc_o; h_inst = inst_o; h_pred = prediction_o;

                if (if_valid && (!stall || ex_redirect)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_slot", 1, 0);
                    end else begin
                        it_got = exp_q.pop_front();
                        if (!stall) begin
                            check("slot_pc", pc_o, it_got.pc);
                            check("slot_inst", inst_o, it_got.inst);
                            check("slot_pred", prediction_o, it_got.pred);
                            delivered++;
                        end
                    end
                end
            end
        end
    end

endmodule
